// File: rtl/flasher_pkg.sv
// Shared definitions for the bound flasher: state encodings, lamp targets and the
// lamp update applied on every step.
package flasher_pkg;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_UP1  = 3'd1,
    S_DN1  = 3'd2,
    S_UP2  = 3'd3,
    S_DN2  = 3'd4,
    S_UP3  = 3'd5,
    S_DN3  = 3'd6,
    S_ILL  = 3'd7
  } state_t;

  localparam logic [15:0] LAMP_6    = 16'h003F;
  localparam logic [15:0] LAMP_11   = 16'h07FF;
  localparam logic [15:0] LAMP_5    = 16'h001F;
  localparam logic [15:0] LAMP_ALL  = 16'hFFFF;
  localparam logic [15:0] LAMP_NONE = 16'h0000;

  // Driven by the target state so the lamp turns at a boundary instead of overshooting;
  // the shifts saturate naturally at all-on / all-off.
  function automatic logic [15:0] lamp_step(input state_t nxt, input logic [15:0] lamp);
    case (nxt)
      S_UP1, S_UP2, S_UP3: return {lamp[14:0], 1'b1};
      S_DN1, S_DN2, S_DN3: return {1'b0, lamp[15:1]};
      default:             return LAMP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/flasher_step_div.sv
// Step pacing divider: asserts step once every STEP_DIV clocks.
module flasher_step_div #(
  parameter int unsigned STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic step
);

  localparam int unsigned W = $clog2(STEP_DIV + 1);
  localparam logic [W-1:0] LAST = W'(STEP_DIV - 1);

  logic [W-1:0] count;

  assign step = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (step) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/flasher_lamp_reg.sv
// Sequential stage of the bound flasher: state register, lamp shift register,
// step divider and the synchronised, latched flick request.
module flasher_lamp_reg
  import flasher_pkg::*;
#(
  parameter int unsigned STEP_DIV    = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flick_in,
  input  logic [2:0]  next,
  output logic [2:0]  current,
  output logic [15:0] lamp,
  output logic        flick
);

  logic                   step;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   fs;
  logic                   pending;
  state_t                 cur_q, cur_d, next_s;
  logic [15:0]            lamp_q, lamp_d;

  flasher_step_div #(.STEP_DIV(STEP_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .step (step)
  );

  assign fs     = sync_q[SYNC_STAGES-1];
  assign next_s = state_t'(next);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], flick_in};
    end
  end

  // Set has priority over the step clear so a held button stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (fs) begin
      pending <= 1'b1;
    end else if (step) begin
      pending <= 1'b0;
    end
  end

  always_comb begin
    cur_d  = cur_q;
    lamp_d = lamp_q;
    if (step) begin
      cur_d  = (next_s == S_ILL) ? S_INIT : next_s;
      lamp_d = lamp_step(next_s, lamp_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q  <= S_INIT;
      lamp_q <= LAMP_NONE;
    end else begin
      cur_q  <= cur_d;
      lamp_q <= lamp_d;
    end
  end

  assign current = cur_q;
  assign lamp    = lamp_q;
  assign flick   = pending;

endmodule

// File: tb/tb_flasher_lamp_reg.sv
// Bench for flasher_lamp_reg with a reference next-state model closed around two
// instances (STEP_DIV=1 and STEP_DIV=4).
module tb_flasher_lamp_reg;

  typedef struct {
    logic [2:0]  nxt;
    logic [2:0]  cur;
    logic [15:0] lamp;
  } vec_t;

  typedef struct {
    logic [2:0]  cur;
    logic [15:0] lamp;
    logic        flick;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst4, fin1, fin4, ovr1, ovr4;
  logic [2:0]  oval1, oval4, next1, next4, cur1, cur4;
  logic [15:0] lamp1, lamp4;
  logic        flick1, flick4;

  int tests = 0;
  int fails = 0;
  exp_t q[$];

  function automatic logic [2:0] ns(input logic [2:0] c, input logic [15:0] l, input logic f);
    case (c)
      3'd0:    ns = f ? 3'd1 : 3'd0;
      3'd1:    ns = (l == 16'h003F) ? 3'd2 : 3'd1;
      3'd2:    ns = (l == 16'h0000) ? 3'd3 : 3'd2;
      3'd3:    ns = (f && l == 16'h003F) ? 3'd2 : (l == 16'h07FF) ? 3'd4 : 3'd3;
      3'd4:    ns = (l == 16'h001F) ? 3'd5 : 3'd4;
      3'd5:    ns = (f && l == 16'h07FF) ? 3'd4 : (l == 16'hFFFF) ? 3'd6 : 3'd5;
      3'd6:    ns = (l == 16'h0000) ? 3'd0 : 3'd6;
      default: ns = 3'd0;
    endcase
  endfunction

  assign next1 = ovr1 ? oval1 : ns(cur1, lamp1, flick1);
  assign next4 = ovr4 ? oval4 : ns(cur4, lamp4, flick4);

  flasher_lamp_reg #(.STEP_DIV(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst1), .flick_in(fin1), .next(next1),
    .current(cur1), .lamp(lamp1), .flick(flick1)
  );

  flasher_lamp_reg #(.STEP_DIV(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst4), .flick_in(fin4), .next(next4),
    .current(cur4), .lamp(lamp4), .flick(flick4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input bit sel4, input logic [2:0] c, input logic [15:0] l,
                          input int maxc, input string name);
    int n = 0;
    while (!(sel4 ? (cur4 == c && lamp4 == l) : (cur1 == c && lamp1 == l)) && n < maxc) begin
      tick();
      n++;
    end
    chk(name, sel4 ? {13'd0, cur4, lamp4} : {13'd0, cur1, lamp1}, {13'd0, c, l});
  endtask

  task automatic build_trip();
    logic [15:0] l = 16'h0000;
    do begin l = {l[14:0], 1'b1}; q.push_back('{3'd1, l, 1'b0}); end while (l != 16'h003F);
    do begin l = {1'b0, l[15:1]}; q.push_back('{3'd2, l, 1'b0}); end while (l != 16'h0000);
    do begin l = {l[14:0], 1'b1}; q.push_back('{3'd3, l, 1'b0}); end while (l != 16'h07FF);
    do begin l = {1'b0, l[15:1]}; q.push_back('{3'd4, l, 1'b0}); end while (l != 16'h001F);
    do begin l = {l[14:0], 1'b1}; q.push_back('{3'd5, l, 1'b0}); end while (l != 16'hFFFF);
    do begin l = {1'b0, l[15:1]}; q.push_back('{3'd6, l, 1'b0}); end while (l != 16'h0000);
    q.push_back('{3'd0, 16'h0000, 1'b0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    exp_t e;
    int   steps;

    vecs = '{'{3'd1, 3'd1, 16'h0001}, '{3'd1, 3'd1, 16'h0003}, '{3'd3, 3'd3, 16'h0007},
             '{3'd2, 3'd2, 16'h0003}, '{3'd4, 3'd4, 16'h0001}, '{3'd6, 3'd6, 16'h0000},
             '{3'd6, 3'd6, 16'h0000}, '{3'd5, 3'd5, 16'h0001}, '{3'd0, 3'd0, 16'h0000},
             '{3'd5, 3'd5, 16'h0001}, '{3'd5, 3'd5, 16'h0003}, '{3'd7, 3'd0, 16'h0000}};

    rst1 = 1'b1; rst4 = 1'b1; fin1 = 1'b0; fin4 = 1'b0;
    ovr1 = 1'b0; ovr4 = 1'b0; oval1 = 3'd0; oval4 = 3'd0;

    // Reset and idle hold
    repeat (2) tick();
    chk("rst_cur1", 32'(cur1), 32'd0);
    chk("rst_lamp1", 32'(lamp1), 32'h0);
    chk("rst_flick1", 32'(flick1), 32'd0);
    chk("rst_cur4", 32'(cur4), 32'd0);
    chk("rst_lamp4", 32'(lamp4), 32'h0);
    rst1 = 1'b0; rst4 = 1'b0;
    repeat (3) begin
      tick();
      chk("idle_state1", {12'd0, flick1, cur1, lamp1}, 32'h0);
    end

    // Lamp update table with next driven directly
    ovr1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      oval1 = vecs[i].nxt;
      q.push_back('{vecs[i].cur, vecs[i].lamp, 1'b0});
      tick();
      e = q.pop_front();
      chk($sformatf("vec%0d_cur", i), 32'(cur1), 32'(e.cur));
      chk($sformatf("vec%0d_lamp", i), 32'(lamp1), 32'(e.lamp));
    end
    oval1 = 3'd1;
    repeat (17) tick();
    chk("sat_up_lamp", 32'(lamp1), 32'hFFFF);
    oval1 = 3'd2;
    repeat (17) tick();
    chk("sat_dn_lamp", 32'(lamp1), 32'h0);
    oval1 = 3'd0;
    tick();
    ovr1 = 1'b0;
    chk("table_end_cur", 32'(cur1), 32'd0);

    // Full trip from a single 1-clock flick pulse
    fin1 = 1'b1;
    tick();
    fin1 = 1'b0;
    chk("flick_lat1", 32'(flick1), 32'd0);
    tick();
    chk("flick_lat2", 32'(flick1), 32'd0);
    tick();
    chk("flick_lat3", 32'(flick1), 32'd1);
    chk("flick_lat3_cur", 32'(cur1), 32'd0);
    build_trip();
    steps = 0;
    while (q.size() > 0) begin
      tick();
      e = q.pop_front();
      steps++;
      chk($sformatf("trip%0d_cur", steps), 32'(cur1), 32'(e.cur));
      chk($sformatf("trip%0d_lamp", steps), 32'(lamp1), 32'(e.lamp));
      chk($sformatf("trip%0d_flick", steps), 32'(flick1), 32'(e.flick));
    end

    // Kickback from S3 with the button held
    fin1 = 1'b1;
    tick();
    fin1 = 1'b0;
    wait_for(1'b0, 3'd3, 16'h0001, 100, "reach_s3");
    fin1 = 1'b1;
    wait_for(1'b0, 3'd3, 16'h003F, 50, "s3_at_lamp6");
    tick();
    chk("kick_cur", 32'(cur1), 32'd2);
    chk("kick_lamp", 32'(lamp1), 32'h001F);
    chk("kick_flick", 32'(flick1), 32'd1);
    fin1 = 1'b0;
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;

    // Step pacing with STEP_DIV=4, flick pulse mid-interval
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    tick();
    fin4 = 1'b1;
    tick();
    fin4 = 1'b0;
    chk("div4_flick_e2", 32'(flick4), 32'd0);
    tick();
    chk("div4_flick_e3", 32'(flick4), 32'd0);
    tick();
    chk("div4_flick_e4", 32'(flick4), 32'd1);
    chk("div4_cur_e4", 32'(cur4), 32'd0);
    repeat (3) tick();
    chk("div4_flick_e7", 32'(flick4), 32'd1);
    chk("div4_cur_e7", 32'(cur4), 32'd0);
    tick();
    chk("div4_cur_e8", 32'(cur4), 32'd1);
    chk("div4_lamp_e8", 32'(lamp4), 32'h0001);
    chk("div4_flick_e8", 32'(flick4), 32'd0);
    repeat (3) tick();
    chk("div4_lamp_e11", 32'(lamp4), 32'h0001);
    tick();
    chk("div4_lamp_e12", 32'(lamp4), 32'h0003);

    // Reset mid-trip, then divider restart and illegal next
    wait_for(1'b1, 3'd5, 16'h03FF, 400, "reach_s5_3ff");
    tick();
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    chk("midrst_cur", 32'(cur4), 32'd0);
    chk("midrst_lamp", 32'(lamp4), 32'h0);
    chk("midrst_flick", 32'(flick4), 32'd0);
    ovr4 = 1'b1;
    oval4 = 3'd1;
    repeat (3) tick();
    chk("restart_lamp_e3", 32'(lamp4), 32'h0);
    tick();
    chk("restart_lamp_e4", 32'(lamp4), 32'h0001);
    chk("restart_cur_e4", 32'(cur4), 32'd1);
    oval4 = 3'd7;
    repeat (3) tick();
    chk("ill_hold_lamp", 32'(lamp4), 32'h0001);
    tick();
    chk("ill_cur", 32'(cur4), 32'd0);
    chk("ill_lamp", 32'(lamp4), 32'h0);
    ovr4 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
